hazard_ctrl_unit: RTL

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

---
 rtl/hazard_ctrl_unit_pkg.sv | 36 +++
 rtl/hazard_ctrl_unit_sat_counter.sv | 33 +++
 rtl/hazard_ctrl_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared definitions for the hazard control unit: FSM states, output-priority
// encoding and the decode from priority class to pipeline control bits.
package hazard_ctrl_unit_pkg;

    typedef enum logic {
        ST_RUN        = 1'b0,
        ST_LOAD_STALL = 1'b1
    } hz_state_e;

    // Lower code wins: branch flush beats a frozen EX, which beats a load stall.
    localparam logic [1:0] PRIO_BRANCH  = 2'd0;
    localparam logic [1:0] PRIO_MD_BUSY = 2'd1;
    localparam logic [1:0] PRIO_LOAD    = 2'd2;
    localparam logic [1:0] PRIO_NORMAL  = 2'd3;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic if_id_flush;
        logic id_ex_flush;
    } hz_ctrl_t;

    function automatic hz_ctrl_t prio_ctrl(input logic [1:0] prio);
        hz_ctrl_t c;
        case (prio)
            PRIO_BRANCH:  c = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
            PRIO_MD_BUSY: c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            PRIO_LOAD:    c = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
            PRIO_NORMAL:  c = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            default:      c = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating event counter with synchronous clear that overrides the
// same-cycle increment.
module hz_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_r;

    // Count register: clear first, then increment unless already at the ceiling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls, mul/div freeze and taken-branch
// flushes, plus saturating stall/flush performance counters.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]            id_rs_valid,
    input  logic [REG_ADDR_W-1:0]         ex_rd,
    input  logic                          ex_mem_read,
    input  logic                          ex_md_busy,
    input  logic                          ex_branch_taken,
    input  logic                          stat_clr,
    output logic                          pc_write,
    output logic                          if_id_write,
    output logic                          id_ex_write,
    output logic                          if_id_flush,
    output logic                          id_ex_flush,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic [CNT_W-1:0]              flush_cnt
);

    localparam int LD_W = $clog2(LOAD_LAT) + 1;
    localparam logic [LD_W-1:0] LD_INIT = LD_W'(LOAD_LAT - 1);
    localparam logic [LD_W-1:0] LD_ONE  = LD_W'(1);

    hz_state_e       state_r, state_nx_s;
    logic [LD_W-1:0] ld_left_r, ld_left_nx_s;
    logic            src_match_s;
    logic            load_hit_s;
    logic [1:0]      prio_s;
    hz_ctrl_t        ctrl_s;

    // Any read source slot matching the EX destination.
    always_comb begin
        src_match_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_rs_valid[i] && (id_rs[i*REG_ADDR_W +: REG_ADDR_W] == ex_rd)) begin
                src_match_s = 1'b1;
            end else begin
                src_match_s = src_match_s;
            end
        end
    end

    // x0 is never a real dependency; a hit is also ignored while reset is held.
    assign load_hit_s = !rst && ex_mem_read && (ex_rd != '0) && src_match_s;

    // Pick the winning output class for this cycle.
    always_comb begin
        if (ex_branch_taken) begin
            prio_s = PRIO_BRANCH;
        end else if (ex_md_busy) begin
            prio_s = PRIO_MD_BUSY;
        end else if ((state_r == ST_LOAD_STALL) || load_hit_s) begin
            prio_s = PRIO_LOAD;
        end else begin
            prio_s = PRIO_NORMAL;
        end
    end

    // Next-state and remaining-stall bookkeeping.
    always_comb begin
        state_nx_s   = state_r;
        ld_left_nx_s = ld_left_r;
        case (prio_s)
            PRIO_BRANCH: begin
                state_nx_s   = ST_RUN;
                ld_left_nx_s = '0;
            end
            PRIO_MD_BUSY: begin
                state_nx_s   = state_r;
                ld_left_nx_s = ld_left_r;
            end
            PRIO_LOAD: begin
                if (state_r == ST_LOAD_STALL) begin
                    // The hit cycle itself was stall #1, so leave on ld_left==1.
                    if (ld_left_r <= LD_ONE) begin
                        state_nx_s   = ST_RUN;
                        ld_left_nx_s = '0;
                    end else begin
                        state_nx_s   = ST_LOAD_STALL;
                        ld_left_nx_s = ld_left_r - LD_ONE;
                    end
                end else if (LOAD_LAT > 1) begin
                    state_nx_s   = ST_LOAD_STALL;
                    ld_left_nx_s = LD_INIT;
                end else begin
                    state_nx_s   = ST_RUN;
                    ld_left_nx_s = '0;
                end
            end
            default: begin
                state_nx_s   = ST_RUN;
                ld_left_nx_s = '0;
            end
        endcase
    end

    // FSM state and stall-countdown registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_RUN;
            ld_left_r <= '0;
        end else begin
            state_r   <= state_nx_s;
            ld_left_r <= ld_left_nx_s;
        end
    end

    assign ctrl_s      = prio_ctrl(prio_s);
    assign pc_write    = ctrl_s.pc_write;
    assign if_id_write = ctrl_s.if_id_write;
    assign id_ex_write = ctrl_s.id_ex_write;
    assign if_id_flush = ctrl_s.if_id_flush;
    assign id_ex_flush = ctrl_s.id_ex_flush;

    hz_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (!ctrl_s.pc_write),
        .clr (stat_clr),
        .cnt (stall_cnt)
    );

    hz_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ctrl_s.if_id_flush),
        .clr (stat_clr),
        .cnt (flush_cnt)
    );

endmodule
